// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared single-port 256x8 data memory.
// Port 0 has fixed priority; port 1 is forced through after STARVE_LIMIT contended losses.
module dmem_arbiter_rsp (
  input  logic       clk,
  input  logic       reset,
  input  logic       take,
  input  logic [7:0] mem_rdata,
  output logic       rvalid,
  output logic [7:0] rdata
);
  logic vld_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= 1'b0;
      rdata <= 8'h00;
    end else begin
      vld_q <= take;
      if (take) rdata <= mem_rdata;
    end
  end

  // A response in flight when reset asserts must never be seen by the requester.
  assign rvalid = vld_q & reset;
endmodule

module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic       p0_gnt,
  output logic       p0_rvalid,
  output logic [7:0] p0_rdata,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic       p1_gnt,
  output logic       p1_rvalid,
  output logic [7:0] p1_rdata,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic [NUM_PORTS-1:0]      req, gnt, take, rvalid;
  req_t [NUM_PORTS-1:0]      rq;
  logic [NUM_PORTS-1:0][7:0] rdata;
  logic [3:0]                starve_cnt;
  logic                      starved;

  assign req   = {p1_req, p0_req};
  assign rq[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign rq[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    gnt = '0;
    if (reset) begin
      if (req[0] && !(req[1] && starved)) gnt[0] = 1'b1;
      else if (req[1])                    gnt[1] = 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        mem_we    = rq[i].we;
        mem_addr  = rq[i].addr;
        mem_wdata = rq[i].wdata;
      end
    end
  end

  // Counts consecutive port 0 wins while port 1 waits; any break in the wait clears it.
  always_ff @(posedge clk) begin
    if (!reset)                 starve_cnt <= 4'd0;
    else if (gnt[0] && req[1])  starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
    else                        starve_cnt <= 4'd0;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign take[i] = gnt[i] & ~rq[i].we;
    dmem_arbiter_rsp u_rsp (
      .clk       (clk),
      .reset     (reset),
      .take      (take[i]),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid[i]),
      .rdata     (rdata[i])
    );
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected read data, monitors pop on rvalid.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [7:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we;
  logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                     input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Check grants mid-cycle, queue the read data a granted read must return, advance one cycle.
  task automatic step(input string nm, input bit g0, input bit g1, input logic [7:0] rd);
    @(negedge clk);
    chk({nm, ".p0_gnt"}, p0_gnt, g0);
    chk({nm, ".p1_gnt"}, p1_gnt, g1);
    if (g0 && !p0_we) q0.push_back(rd);
    if (g1 && !p1_we) q1.push_back(rd);
    @(posedge clk); #1;
  endtask

  logic [7:0] e0, e1;
  always @(negedge clk) begin
    if (p0_rvalid) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL p0_rvalid: got unexpected response %0h expected none", p0_rdata);
      end else begin
        e0 = q0.pop_front();
        if (p0_rdata !== e0) begin
          n_err++;
          $display("FAIL p0_rdata: got %0h expected %0h", p0_rdata, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (p1_rvalid) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL p1_rvalid: got unexpected response %0h expected none", p1_rdata);
      end else begin
        e1 = q1.pop_front();
        if (p1_rdata !== e1) begin
          n_err++;
          $display("FAIL p1_rdata: got %0h expected %0h", p1_rdata, e1);
        end
      end
    end
  end

  initial begin
    // Reset held with both ports requesting
    reset = 1'b0;
    drv(1, 1, 8'h33, 8'h77, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    chk("rst.p0_gnt", p0_gnt, 0);
    chk("rst.p1_gnt", p1_gnt, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 8'h00);
    chk("rst.mem_wdata", mem_wdata, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.p0_rvalid", p0_rvalid, 0);
    chk("rst.p1_rvalid", p1_rvalid, 0);
    chk("rst.p0_rdata", p0_rdata, 8'h00);
    chk("rst.p1_rdata", p1_rdata, 8'h00);
    @(posedge clk); #1;

    // Release: p0 wins first cycle, writes 0x5A to 0x10
    reset = 1'b1;
    drv(1, 1, 8'h10, 8'h5A, 1, 0, 8'h20, 8'h00);
    #2;
    chk("wr.mem_we", mem_we, 1);
    chk("wr.mem_addr", mem_addr, 8'h10);
    chk("wr.mem_wdata", mem_wdata, 8'h5A);
    step("rel", 1, 0, 8'h00);

    // p0 reads back the just-written byte
    drv(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #2;
    chk("rd.mem_we", mem_we, 0);
    chk("rd.mem_addr", mem_addr, 8'h10);
    step("rd10", 1, 0, 8'h5A);

    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    #2;
    chk("idle.mem_addr", mem_addr, 8'h00);
    chk("idle.mem_we", mem_we, 0);
    step("idle", 0, 0, 8'h00);

    // Cross-port coherence: p1 writes 0xFF, p0 reads it the next cycle
    drv(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'hC3);
    step("p1wr", 0, 1, 8'h00);
    drv(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    step("p0rdFF", 1, 0, 8'hC3);

    // Continuous contention: p0 x4, p1, p0 x4, p1
    drv(1, 0, 8'h10, 8'h00, 1, 1, 8'h80, 8'h99);
    for (int k = 0; k < 4; k++) step("cont_a", 1, 0, 8'h5A);
    step("cont_a.p1", 0, 1, 8'h00);
    for (int k = 0; k < 4; k++) step("cont_b", 1, 0, 8'h5A);
    step("cont_b.p1", 0, 1, 8'h00);

    drv(1, 0, 8'h80, 8'h00, 0, 0, 8'h00, 8'h00);
    step("rd80", 1, 0, 8'h99);

    // p1 waits 3, drops a cycle, then must wait 4 more contended p0 grants
    drv(1, 0, 8'h10, 8'h00, 1, 0, 8'hFF, 8'h00);
    for (int k = 0; k < 3; k++) step("drop_a", 1, 0, 8'h5A);
    drv(1, 0, 8'h10, 8'h00, 0, 0, 8'hFF, 8'h00);
    step("drop", 1, 0, 8'h5A);
    drv(1, 0, 8'h10, 8'h00, 1, 0, 8'hFF, 8'h00);
    for (int k = 0; k < 4; k++) step("drop_b", 1, 0, 8'h5A);
    step("drop_b.p1", 0, 1, 8'hC3);

    drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    step("p1rd10", 0, 1, 8'h5A);

    // p1 read granted, reset asserts before its response is seen
    drv(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00);
    @(negedge clk);
    chk("rstrd.p1_gnt", p1_gnt, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rstrd.p1_rvalid", p1_rvalid, 0);
    @(posedge clk); #1;
    chk("rstrd.p1_rdata", p1_rdata, 8'h00);
    chk("rstrd.p1_rvalid2", p1_rvalid, 0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("q0.pending", q0.size(), 0);
    chk("q1.pending", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
